detector_paso: RTL and testbench

Two-beam vehicle direction detector feeding the 3-bit occupancy counter. Synchronises and debounces two infrared barrier sensors, A on the street side and B on the lot side. Tracks the beam-break sequence with an FSM and emits one-cycle `Z0`/`Z1` commands to the counter only for complete, legal passages. Entries while full and exits while empty are refused and flagged.

---
 rtl/detector_paso_pkg.sv | 25 ++
 rtl/detector_paso_antirrebote.sv | 59 +++++
 rtl/detector_paso.sv | 165 ++++++++++++++++
 tb/tb_detector_paso.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_paso_pkg.sv
// -----------------------------------------------------------------------------
// detector_pkg
// Shared types and constants for the two-beam vehicle direction detector.
//   estado_t : FSM states of the beam-break sequence tracker.
//   CMD_*    : command encodings to the occupancy counter, bit order {Z1,Z0}.
//              {1,1} is deliberately absent: the counter treats it as clear.
// -----------------------------------------------------------------------------
package detector_pkg;

  typedef enum logic [2:0] {
    IDLE,    // no beam blocked
    ENT_A,   // entry: street beam only
    ENT_AB,  // entry: both beams
    ENT_B,   // entry: lot beam only
    SAL_B,   // exit: lot beam only
    SAL_BA,  // exit: both beams
    SAL_A,   // exit: street beam only
    BLOQ     // locked out until both beams clear
  } estado_t;

  localparam logic [1:0] CMD_NADA = 2'b00;
  localparam logic [1:0] CMD_INC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;

endpackage : detector_pkg

// File: rtl/detector_paso_antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote
// Two-flop synchroniser followed by a debouncer for one infrared barrier.
// The debounced level adopts the synchronised value only after the two have
// disagreed for DEB_CYCLES consecutive cycles; any agreement restarts the run.
// Raw edge to level change is 2 + DEB_CYCLES cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw sensor, asynchronous to clk, 1 = beam blocked
//   nivel      : debounced, synchronous level
// -----------------------------------------------------------------------------
module antirrebote #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic nivel
);

  // Counter only needs to reach DEB_CYCLES-1; the last step commits the level.
  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          nivel_q, nivel_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    cnt_d   = '0;
    nivel_d = nivel_q;
    if (sync2_q != nivel_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        nivel_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; this is what makes the two-flop chain a real chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      nivel_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
    end
  end

  assign nivel = nivel_q;

endmodule : antirrebote

// File: rtl/detector_paso.sv
// -----------------------------------------------------------------------------
// detector_paso
// Direction detector for a car-park gate with two infrared beams: A on the
// street side, B on the lot side. Debounces both beams, tracks the break
// sequence and issues one-cycle commands to a 3-bit occupancy counter only for
// complete, legal passages.
//   clk, rst_n : clock, asynchronous active-low reset
//   sensor_a   : raw beam A (street), 1 = blocked
//   sensor_b   : raw beam B (lot), 1 = blocked
//   lleno      : counter is full (count = 7)
//   cuenta     : current counter value
//   Z0         : increment pulse (one entry)
//   Z1         : decrement pulse (one exit)
//   rechazo    : pulse, entry completed while full (no Z0 issued)
//   error      : pulse, exit while empty, timeout, or both beams from IDLE
//   ocupado    : FSM is outside IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
import detector_pkg::*;

module detector_paso #(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       lleno,
  input  logic [2:0] cuenta,
  output logic       Z0,
  output logic       Z1,
  output logic       rechazo,
  output logic       error,
  output logic       ocupado
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic a_d, b_d;
  logic [1:0] par;

  estado_t state_q, state_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0] cmd_q, cmd_d;
  logic rechazo_q, rechazo_d;
  logic error_q, error_d;
  logic ocupado_q;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sensor_a),
    .nivel (a_d)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sensor_b),
    .nivel (b_d)
  );

  assign par = {a_d, b_d};

  always_comb begin
    state_d   = state_q;
    cmd_d     = CMD_NADA;
    rechazo_d = 1'b0;
    error_d   = 1'b0;
    to_d      = '0;

    unique case (state_q)
      IDLE: begin
        unique case (par)
          2'b10: state_d = ENT_A;
          2'b01: state_d = SAL_B;
          2'b11: begin
            // Both beams at once cannot be told apart as entry or exit.
            state_d = BLOQ;
            error_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      ENT_A: begin
        if (par == 2'b11)      state_d = ENT_AB;
        else if (par == 2'b00) state_d = IDLE;   // car backed out
      end
      ENT_AB: begin
        if (par == 2'b01)      state_d = ENT_B;
        else if (par == 2'b10) state_d = ENT_A;
      end
      ENT_B: begin
        if (par == 2'b00) begin
          state_d = IDLE;
          // lleno is only looked at in the completing cycle.
          if (lleno) rechazo_d = 1'b1;
          else       cmd_d     = CMD_INC;
        end else if (par == 2'b11) begin
          state_d = ENT_AB;
        end
      end
      SAL_B: begin
        if (par == 2'b11)      state_d = SAL_BA;
        else if (par == 2'b00) state_d = IDLE;
      end
      SAL_BA: begin
        if (par == 2'b10)      state_d = SAL_A;
        else if (par == 2'b01) state_d = SAL_B;
      end
      SAL_A: begin
        if (par == 2'b00) begin
          state_d = IDLE;
          if (cuenta == 3'd0) error_d = 1'b1;
          else                cmd_d   = CMD_DEC;
        end else if (par == 2'b11) begin
          state_d = SAL_BA;
        end
      end
      BLOQ: begin
        if (par == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Timeout only runs while a sequence is in progress and the state holds;
    // any transition leaves to_d at its cleared default. A completion always
    // changes state, so it can never coincide with a timeout.
    if ((state_q != IDLE) && (state_q != BLOQ) && (state_d == state_q)) begin
      if (to_q == TW'(TIMEOUT - 1)) begin
        state_d = BLOQ;
        error_d = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      to_q      <= '0;
      cmd_q     <= CMD_NADA;
      rechazo_q <= 1'b0;
      error_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      cmd_q     <= cmd_d;
      rechazo_q <= rechazo_d;
      error_q   <= error_d;
      // Registered from the next state so it tracks state_q exactly.
      ocupado_q <= (state_d != IDLE);
    end
  end

  assign Z0      = cmd_q[0];
  assign Z1      = cmd_q[1];
  assign rechazo = rechazo_q;
  assign error   = error_q;
  assign ocupado = ocupado_q;

endmodule : detector_paso

// File: tb/tb_detector_paso.sv
// -----------------------------------------------------------------------------
// tb_detector_paso
// Scoreboard bench: each scenario pushes the output pulses it expects, a
// negedge monitor pops one entry per observed pulse cycle and compares the
// whole {error,rechazo,Z1,Z0} vector. DUT runs with DEB_CYCLES=4, TIMEOUT=50.
// -----------------------------------------------------------------------------
module tb_detector_paso;

  localparam int DEB = 4;
  localparam int TMO = 50;
  localparam int LAT = 2 + DEB + 1;  // raw edge -> debounced level -> FSM register

  localparam logic [3:0] EV_Z0   = 4'b0001;
  localparam logic [3:0] EV_Z1   = 4'b0010;
  localparam logic [3:0] EV_RECH = 4'b0100;
  localparam logic [3:0] EV_ERR  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_a, sensor_b, lleno;
  logic [2:0] cuenta;
  logic       Z0, Z1, rechazo, error, ocupado;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  detector_paso #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .lleno    (lleno),
    .cuenta   (cuenta),
    .Z0       (Z0),
    .Z1       (Z1),
    .rechazo  (rechazo),
    .error    (error),
    .ocupado  (ocupado)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: any cycle with a pulse consumes one expectation,
  // so a two-cycle pulse or a stray pulse shows up as an extra event.
  always @(negedge clk) begin
    logic [3:0] obs;
    logic [3:0] e;
    obs = {error, rechazo, Z1, Z0};
    if (obs != 4'b0000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse t=%0t got=%b want=none", $time, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL pulse t=%0t got=%b want=%b", $time, obs, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing got=%0d_pending want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sensor_a = 1'b0; sensor_b = 1'b0; lleno = 1'b0; cuenta = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({Z0, Z1, rechazo, error, ocupado} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000", {Z0, Z1, rechazo, error, ocupado});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_entry();
    int lat;
    cuenta = 3'd3; lleno = 1'b0;
    exp_q.push_back(EV_Z0);
    hold(1, 0, 20);
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL entry_ocupado got=%b want=1", ocupado);
    end
    hold(1, 1, 20);
    hold(0, 1, 20);
    sensor_a = 1'b0; sensor_b = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (Z0 === 1'b1) begin lat = i; break; end
    end
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL entry_latency got=%0d want=%0d", lat, LAT);
    end
    drain("entry");
  endtask

  task automatic test_exit();
    cuenta = 3'd0;
    exp_q.push_back(EV_ERR);
    hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20); hold(0, 0, 10);
    drain("exit_empty");
    cuenta = 3'd5;
    exp_q.push_back(EV_Z1);
    hold(0, 1, 20); hold(1, 1, 20); hold(1, 0, 20); hold(0, 0, 10);
    drain("exit");
  endtask

  task automatic test_full();
    lleno = 1'b1; cuenta = 3'd7;
    exp_q.push_back(EV_RECH);
    hold(1, 0, 20); hold(1, 1, 20); hold(0, 1, 20); hold(0, 0, 10);
    drain("full");
    lleno = 1'b0; cuenta = 3'd3;
  endtask

  task automatic test_bounce();
    logic seen;
    seen = 1'b0;
    for (int g = 0; g < 3; g++) begin
      sensor_a = 1'b1;
      repeat (3) begin @(negedge clk); if (ocupado) seen = 1'b1; end
      sensor_a = 1'b0;
      repeat (10) begin @(negedge clk); if (ocupado) seen = 1'b1; end
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL glitch_ocupado got=%b want=0", seen);
    end
    drain("glitch");
    // Car noses in and backs out again.
    hold(1, 0, 20);
    hold(0, 0, 20);
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL backout_idle got=%b want=0", ocupado);
    end
    drain("backout");
    // Reversal at ENT_AB back to ENT_A, then completed.
    exp_q.push_back(EV_Z0);
    hold(1, 0, 20); hold(1, 1, 20); hold(1, 0, 20); hold(1, 1, 20);
    hold(0, 1, 20); hold(0, 0, 10);
    drain("reversal");
  endtask

  task automatic test_illegal();
    exp_q.push_back(EV_ERR);
    hold(1, 1, 20);
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL illegal_bloq got=%b want=1", ocupado);
    end
    hold(0, 0, 20);
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL illegal_release got=%b want=0", ocupado);
    end
    drain("illegal");
  endtask

  task automatic test_timeout();
    int c_ent, c_err;
    c_ent = -1; c_err = -1;
    exp_q.push_back(EV_ERR);
    sensor_a = 1'b1; sensor_b = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ocupado && c_ent < 0) c_ent = i;
      if (error && c_err < 0) c_err = i;
    end
    total++;
    if (c_ent < 0 || c_err < 0 || (c_err - c_ent) != TMO) begin
      bad++;
      $display("FAIL timeout_cycles got=%0d want=%0d", c_err - c_ent, TMO);
    end
    total++;
    if (ocupado !== 1'b1) begin
      bad++;
      $display("FAIL timeout_bloq got=%b want=1", ocupado);
    end
    hold(0, 0, 20);
    total++;
    if (ocupado !== 1'b0) begin
      bad++;
      $display("FAIL timeout_release got=%b want=0", ocupado);
    end
    drain("timeout");
  endtask

  task automatic test_reset_mid();
    int lat;
    hold(1, 0, 20);
    hold(1, 1, 20);   // now in ENT_AB
    rst_n = 1'b0;
    #1;
    total++;
    if ({Z0, Z1, rechazo, error, ocupado} !== 5'b0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b want=00000", {Z0, Z1, rechazo, error, ocupado});
    end
    repeat (3) @(negedge clk);
    // Both beams still blocked: re-seen from IDLE as an illegal pair.
    exp_q.push_back(EV_ERR);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (ocupado === 1'b1) begin lat = i; break; end
    end
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL midreset_bloq_latency got=%0d want=%0d", lat, LAT);
    end
    hold(0, 0, 20);
    drain("midreset");
  endtask

  initial begin
    sensor_a = 1'b0; sensor_b = 1'b0; lleno = 1'b0; cuenta = 3'd0; rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_entry();
    test_exit();
    test_full();
    test_bounce();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_detector_paso
